// File: rtl/sa_tile_sched.sv
// sa_tile_sched: walks an n-outer / m-inner tile grid and drives sa_control
// one run at a time, supplying per-run input, weight and output base addresses.
module sa_tile_sched #(
    parameter int INPUT_MEM_WIDTH  = 8,
    parameter int WEIGHT_MEM_WIDTH = 8,
    parameter int OUTPUT_MEM_WIDTH = 8,
    parameter int NUM_ROWS         = 4,
    parameter int NUM_COLS         = 4,
    parameter int TILE_CNT_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [TILE_CNT_WIDTH-1:0]   i_tiles_m,
    input  logic [TILE_CNT_WIDTH-1:0]   i_tiles_n,
    input  logic                        i_abort,
    input  logic                        i_sa_done,
    output logic                        o_sa_start,
    output logic [INPUT_MEM_WIDTH-1:0]  o_input_base,
    output logic [WEIGHT_MEM_WIDTH-1:0] o_weight_base,
    output logic [OUTPUT_MEM_WIDTH-1:0] o_output_base,
    output logic [TILE_CNT_WIDTH-1:0]   o_tile_m,
    output logic [TILE_CNT_WIDTH-1:0]   o_tile_n,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_aborted
);

    localparam logic [INPUT_MEM_WIDTH-1:0] IN_STEP =
        INPUT_MEM_WIDTH'(NUM_ROWS + NUM_COLS - 1);
    localparam logic [WEIGHT_MEM_WIDTH-1:0] WT_STEP =
        WEIGHT_MEM_WIDTH'(NUM_ROWS);
    localparam logic [OUTPUT_MEM_WIDTH-1:0] OUT_STEP =
        OUTPUT_MEM_WIDTH'(NUM_COLS + 1);
    localparam logic [TILE_CNT_WIDTH-1:0] ONE = TILE_CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [TILE_CNT_WIDTH-1:0] tiles_m_q;
    logic [TILE_CNT_WIDTH-1:0] tiles_n_q;
    logic                      abort_pend;
    logic                      accept;
    logic                      m_last;
    logic                      n_last;
    logic                      last_tile;

    assign m_last    = (o_tile_m == tiles_m_q - ONE);
    assign n_last    = (o_tile_n == tiles_n_q - ONE);
    assign last_tile = m_last && n_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and job accept strobe
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    accept = 1'b1;
                    if (i_tiles_m == '0 || i_tiles_n == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // done idles high; only its fall proves the run began
                if (!i_sa_done) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_sa_done) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (abort_pend || last_tile) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Config latch, tile indices and base address walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tiles_m_q     <= '0;
            tiles_n_q     <= '0;
            o_tile_m      <= '0;
            o_tile_n      <= '0;
            o_input_base  <= '0;
            o_weight_base <= '0;
            o_output_base <= '0;
        end else if (accept) begin
            tiles_m_q     <= i_tiles_m;
            tiles_n_q     <= i_tiles_n;
            o_tile_m      <= '0;
            o_tile_n      <= '0;
            o_input_base  <= '0;
            o_weight_base <= '0;
            o_output_base <= '0;
        end else if (state_q == S_ADVANCE) begin
            if (!m_last) begin
                o_tile_m     <= o_tile_m + ONE;
                o_input_base <= o_input_base + IN_STEP;
            end else begin
                o_tile_m      <= '0;
                o_input_base  <= '0;
                o_tile_n      <= o_tile_n + ONE;
                o_weight_base <= o_weight_base + WT_STEP;
            end
            o_output_base <= o_output_base + OUT_STEP;
        end
    end

    // Start pulse, busy/done/aborted status and pending abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sa_start <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_aborted  <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            o_sa_start <= (state_d == S_ISSUE);
            o_done     <= (state_q == S_FINISH);

            if (accept) begin
                o_busy <= 1'b1;
            end else if (state_q == S_FINISH) begin
                o_busy <= 1'b0;
            end

            if (accept) begin
                o_aborted <= 1'b0;
            end else if (state_q == S_ADVANCE && abort_pend) begin
                o_aborted <= 1'b1;
            end

            if (state_d == S_IDLE) begin
                abort_pend <= 1'b0;
            end else if (i_abort && state_q != S_IDLE) begin
                abort_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sa_tile_sched.sv
// tb_sa_tile_sched: directed bench for the tile scheduler with a small
// behavioural stand-in for sa_control's done level.
module tb_sa_tile_sched;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic [3:0] i_tiles_m;
    logic [3:0] i_tiles_n;
    logic       i_abort;
    logic       sa_done;
    logic       o_sa_start;
    logic [7:0] o_input_base;
    logic [7:0] o_weight_base;
    logic [7:0] o_output_base;
    logic [3:0] o_tile_m;
    logic [3:0] o_tile_n;
    logic       o_busy;
    logic       o_done;
    logic       o_aborted;

    int n_chk = 0;
    int n_err = 0;

    int ack_hold = 0;
    int run_len  = 4;
    int starts   = 0;
    int overlap  = 0;
    int done_cnt = 0;
    bit model_busy = 0;
    logic [31:0] run_log[$];

    sa_tile_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_tiles_m     (i_tiles_m),
        .i_tiles_n     (i_tiles_n),
        .i_abort       (i_abort),
        .i_sa_done     (sa_done),
        .o_sa_start    (o_sa_start),
        .o_input_base  (o_input_base),
        .o_weight_base (o_weight_base),
        .o_output_base (o_output_base),
        .o_tile_m      (o_tile_m),
        .o_tile_n      (o_tile_n),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_aborted     (o_aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < run_log.size()) return run_log[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({o_sa_start, o_input_base, o_weight_base, o_output_base,
                    o_tile_m, o_tile_n, o_busy, o_done, o_aborted});
    endfunction

    // sa_control stand-in: done idles high, drops after ack_hold, rises after run_len
    initial begin
        sa_done = 1'b1;
        forever begin
            @(negedge clk);
            if (o_sa_start) begin
                starts++;
                model_busy = 1;
                run_log.push_back({o_tile_m, o_tile_n, o_input_base,
                                   o_weight_base, o_output_base});
                for (int i = 0; i < ack_hold; i++) begin
                    @(negedge clk);
                    if (o_sa_start) overlap++;
                end
                sa_done = 1'b0;
                for (int i = 0; i < run_len; i++) begin
                    @(negedge clk);
                    if (o_sa_start) overlap++;
                end
                sa_done = 1'b1;
                model_busy = 0;
            end
        end
    end

    // o_done pulse counter
    initial begin
        forever begin
            @(negedge clk);
            if (o_done) done_cnt++;
        end
    end

    task automatic kick(input logic [3:0] m, input logic [3:0] n);
        i_tiles_m = m;
        i_tiles_n = n;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output bit seen);
        lat = 1;
        while (!o_done && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        seen = o_done;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int c;
        c = 0;
        while (starts < target && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    int  s0, d0, lb, lat;
    bit  seen;

    initial begin
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_tiles_m = '0;
        i_tiles_n = '0;
        i_abort   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2x2 grid, n outer / m inner
        s0 = starts; d0 = done_cnt; lb = run_log.size();
        ack_hold = 0; run_len = 4;
        kick(4'd2, 4'd2);
        check("t1_busy", 64'(o_busy), 64'd1);
        wait_done(400, lat, seen);
        check("t1_done_seen", 64'(seen), 64'd1);
        check("t1_starts", 64'(starts - s0), 64'd4);
        check("t1_run0", 64'(log_at(lb + 0)), 64'h0000_0000);
        check("t1_run1", 64'(log_at(lb + 1)), 64'h1007_0005);
        check("t1_run2", 64'(log_at(lb + 2)), 64'h0100_040A);
        check("t1_run3", 64'(log_at(lb + 3)), 64'h1107_040F);
        check("t1_aborted", 64'(o_aborted), 64'd0);
        check("t1_busy_off", 64'(o_busy), 64'd0);
        repeat (3) @(negedge clk);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t1_overlap", 64'(overlap), 64'd0);

        // empty job: no runs, done two cycles after start
        s0 = starts;
        kick(4'd0, 4'd3);
        check("t2_busy", 64'(o_busy), 64'd1);
        check("t2_done_early", 64'(o_done), 64'd0);
        @(negedge clk);
        check("t2_done", 64'(o_done), 64'd1);
        check("t2_busy_off", 64'(o_busy), 64'd0);
        repeat (3) @(negedge clk);
        check("t2_starts", 64'(starts - s0), 64'd0);

        // done stays high 3 cycles after start: must not count as completion
        s0 = starts; d0 = done_cnt;
        ack_hold = 3; run_len = 3;
        i_tiles_m = 4'd1;
        i_tiles_n = 4'd1;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
        wait_done(200, lat, seen);
        check("t3_latency", 64'(lat), 64'd10);
        repeat (8) @(negedge clk);
        check("t3_starts", 64'(starts - s0), 64'd1);
        check("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t3_overlap", 64'(overlap), 64'd0);
        ack_hold = 0; run_len = 4;

        // abort during run 2 of 4
        s0 = starts; d0 = done_cnt;
        kick(4'd2, 4'd2);
        wait_starts(s0 + 2, 200);
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("t4_still_busy", 64'(o_busy), 64'd1);
        wait_done(200, lat, seen);
        check("t4_done_seen", 64'(seen), 64'd1);
        check("t4_aborted", 64'(o_aborted), 64'd1);
        repeat (12) @(negedge clk);
        check("t4_starts", 64'(starts - s0), 64'd2);
        check("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

        // start while busy is ignored; start right after done is taken
        s0 = starts; lb = run_log.size();
        kick(4'd2, 4'd1);
        @(negedge clk);
        i_tiles_m = 4'd3;
        i_tiles_n = 4'd3;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
        wait_done(300, lat, seen);
        check("t5_done_seen", 64'(seen), 64'd1);
        check("t5_starts", 64'(starts - s0), 64'd2);
        check("t5_run1", 64'(log_at(lb + 1)), 64'h1007_0005);
        @(negedge clk);
        s0 = starts; lb = run_log.size();
        kick(4'd1, 4'd1);
        check("t5_restart_busy", 64'(o_busy), 64'd1);
        check("t5_abort_clr", 64'(o_aborted), 64'd0);
        wait_done(200, lat, seen);
        check("t5_restart_done", 64'(seen), 64'd1);
        check("t5_restart_run0", 64'(log_at(lb)), 64'h0000_0000);

        // async reset in WAIT_DONE of run 2, then a fresh job
        run_len = 8;
        s0 = starts;
        kick(4'd2, 4'd2);
        wait_starts(s0 + 2, 200);
        repeat (3) @(negedge clk);
        check("t6_pre_in", 64'(o_input_base), 64'd7);
        #2 rst_n = 1'b0;
        #1 check("t6_rst_outs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50 && model_busy; c++) @(negedge clk);
        @(negedge clk);
        run_len = 4;
        s0 = starts; lb = run_log.size();
        kick(4'd1, 4'd1);
        wait_done(200, lat, seen);
        check("t6_done_seen", 64'(seen), 64'd1);
        check("t6_starts", 64'(starts - s0), 64'd1);
        check("t6_run0", 64'(log_at(lb)), 64'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
